// File: rtl/char_seq_match.sv
// Streaming pattern matcher: finds the first occurrence of a programmable pattern
// (with '.' wildcards) in a character stream. Define CHAR_CASE_FOLD_EN for case-insensitive letters.
module char_seq_match #(
  parameter int CHAR_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int IDX_W   = 3,
  parameter int POS_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [CHAR_W-1:0] cfg_char,
  input  logic [IDX_W:0]    cfg_len,
  input  logic              start,
  input  logic              x_valid,
  input  logic [CHAR_W-1:0] x,
  input  logic              x_last,
  output logic              busy,
  output logic              rdy,
  output logic              y,
  output logic [POS_W-1:0]  match_pos
);

  // Handshake: x is consumed on every SCAN cycle with x_valid=1 (no backpressure).
  // rdy is a level held in DONE; y and match_pos are valid whenever rdy=1 and
  // stay put until the next start or reset.

  localparam int LEN_W = IDX_W + 1;
  localparam logic [CHAR_W-1:0] WILDCARD = CHAR_W'(8'h2E);
  localparam logic [POS_W-1:0]  POS_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state_q, state_d;

  logic [CHAR_W-1:0] pat_q [MAX_LEN];
  logic [CHAR_W-1:0] win_q [MAX_LEN];
  logic [CHAR_W-1:0] win_d [MAX_LEN];
  logic [LEN_W-1:0]  len_q, len_start, fill_q;
  logic [POS_W-1:0]  pos_q, match_pos_q;
  logic              y_q, hit;

`ifdef CHAR_CASE_FOLD_EN
  function automatic logic is_letter(input logic [CHAR_W-1:0] c);
    return (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) ||
           (c >= CHAR_W'(8'h61) && c <= CHAR_W'(8'h7A));
  endfunction
`endif

  function automatic logic char_match(input logic [CHAR_W-1:0] s,
                                      input logic [CHAR_W-1:0] p);
    if (p == WILDCARD) return 1'b1;
`ifdef CHAR_CASE_FOLD_EN
    // Upper/lower case letters differ only in bit 5.
    if (is_letter(s) && is_letter(p))
      return (s | CHAR_W'(8'h20)) == (p | CHAR_W'(8'h20));
`endif
    return s == p;
  endfunction

  assign len_start = (int'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;

  // Candidate window with the incoming character at index 0.
  always_comb begin
    win_d[0] = x;
    for (int k = 1; k < MAX_LEN; k++) win_d[k] = win_q[k-1];
    hit = (int'(fill_q) + 1 >= int'(len_q));
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < int'(len_q)) begin
        if (!char_match(win_d[k], pat_q[IDX_W'(int'(len_q) - 1 - k)])) hit = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (len_start == '0) ? DONE : SCAN;
      SCAN: begin
        if (start)                           state_d = (len_start == '0) ? DONE : SCAN;
        else if (x_valid && (hit || x_last)) state_d = DONE;
      end
      DONE: if (start) state_d = (len_start == '0) ? DONE : SCAN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        pat_q[i] <= '0;
        win_q[i] <= '0;
      end
      len_q       <= '0;
      fill_q      <= '0;
      pos_q       <= '0;
      y_q         <= 1'b0;
      match_pos_q <= '0;
    end else begin
      if (cfg_we && state_q != SCAN && int'(cfg_addr) < MAX_LEN)
        pat_q[cfg_addr] <= cfg_char;
      if (start) begin
        len_q       <= len_start;
        fill_q      <= '0;
        pos_q       <= '0;
        y_q         <= (len_start == '0);
        match_pos_q <= '0;
        for (int i = 0; i < MAX_LEN; i++) win_q[i] <= '0;
      end else if (state_q == SCAN && x_valid) begin
        win_q <= win_d;
        if (int'(fill_q) < MAX_LEN) fill_q <= fill_q + 1'b1;
        if (hit) begin
          y_q         <= 1'b1;
          match_pos_q <= pos_q;
        end else if (x_last) begin
          y_q         <= 1'b0;
          match_pos_q <= pos_q;
        end else if (pos_q != POS_MAX) begin
          pos_q <= pos_q + 1'b1;
        end
      end
    end
  end

  assign busy      = (state_q == SCAN);
  assign rdy       = (state_q == DONE);
  assign y         = y_q;
  assign match_pos = match_pos_q;

endmodule
